// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter serialising byte-wide reads/writes onto one memory port.
// Reads have a two-cycle memory latency; writes retire one byte per cycle.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 0,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*2-1:0]      len_i,
  input  logic [NUM_PORTS*32-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        done_o,
  output logic [31:0]                 rdata_o,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t st, st_n;
  logic [PW-1:0] lst, lst_n, win;
  logic [NUM_PORTS-1:0] gnt_n;
  logic [ADDR_W-1:0] a, a_n, ma_n;
  logic [31:0] wd, wd_n, rb, rb_n, rd_n;
  logic [2:0] n, n_n, ia, ia_n, ca, ca_n;
  logic [1:0] v, v_n, ln;
  logic [7:0] md_n;
  logic wr_q, wr_n, rdy_q, fnd;
  int wi, j;
  always_comb begin
    fnd = 1'b0;
    wi = 0;
    j = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = ARB_MODE == 1 ? (int'(lst) + 1 + i) % NUM_PORTS : i;
      if (!fnd && req_i[j]) begin
        fnd = 1'b1;
        wi = j;
      end
    end
  end
  assign win = PW'(wi);
  assign ln = len_i[wi*2 +: 2];
  assign done_o = st == DONE ? gnt_o : '0;
  assign mem_wr = wr_q & rdy_in;
  // v tracks read addresses in flight; a rising rdy_q edge means the pipeline was lost
  always_comb begin
    st_n = st;
    lst_n = lst;
    gnt_n = gnt_o;
    a_n = a;
    n_n = n;
    wd_n = wd;
    ia_n = ia;
    ca_n = ca;
    v_n = v;
    rb_n = rb;
    rd_n = rdata_o;
    ma_n = mem_a;
    md_n = mem_dout;
    wr_n = 1'b0;
    case (st)
      IDLE: if (fnd) begin
        lst_n = win;
        gnt_n = NUM_PORTS'(1) << win;
        a_n = addr_i[wi*ADDR_W +: ADDR_W];
        n_n = ln == 2'd0 ? 3'd1 : ln == 2'd1 ? 3'd2 : 3'd4;
        wd_n = wdata_i[wi*32 +: 32];
        ia_n = 3'd1;
        ca_n = 3'd0;
        v_n = 2'b01;
        rb_n = '0;
        ma_n = a_n;
        md_n = wd_n[7:0];
        wr_n = we_i[wi];
        st_n = we_i[wi] ? WRITE : READ;
      end
      READ: if (!rdy_q) begin
        ma_n = a + ADDR_W'(ca);
        ia_n = ca + 3'd1;
        v_n = 2'b01;
      end else begin
        if (v[1]) begin
          rb_n = rb | ({24'd0, mem_din} << {ca, 3'b000});
          ca_n = ca + 3'd1;
          if (ca == n - 3'd1) begin
            st_n = DONE;
            rd_n = rb_n;
          end
        end
        if (ia < n) begin
          ma_n = a + ADDR_W'(ia);
          ia_n = ia + 3'd1;
        end
        v_n = {v[0], ia < n};
      end
      WRITE: if (ia == n) st_n = DONE;
      else begin
        ma_n = a + ADDR_W'(ia);
        md_n = wd[{ia[1:0], 3'b000} +: 8];
        wr_n = 1'b1;
        ia_n = ia + 3'd1;
      end
      DONE: begin
        st_n = IDLE;
        gnt_n = '0;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      st <= IDLE;
      lst <= PW'(NUM_PORTS - 1);
      gnt_o <= '0;
      a <= '0;
      n <= '0;
      wd <= '0;
      ia <= '0;
      ca <= '0;
      v <= '0;
      rb <= '0;
      rdata_o <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      wr_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_in) begin
        st <= st_n;
        lst <= lst_n;
        gnt_o <= gnt_n;
        a <= a_n;
        n <= n_n;
        wd <= wd_n;
        ia <= ia_n;
        ca <= ca_n;
        v <= v_n;
        rb <= rb_n;
        rdata_o <= rd_n;
        mem_a <= ma_n;
        mem_dout <= md_n;
        wr_q <= wr_n;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for a fixed-priority and a round-robin mem_arbiter side by side.
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic [1:0] req_i = '0;
  logic [1:0] we_i = '0;
  logic [63:0] addr_i = '0;
  logic [3:0] len_i = '0;
  logic [63:0] wdata_i = '0;
  logic [1:0] gnt0, gnt1, done0, done1;
  logic [31:0] rd0, rd1, ma0, ma1;
  logic [7:0] din0, din1, dout0, dout1;
  logic wr0, wr1;
  logic [7:0] wlog [4];
  int checks = 0;
  int fails = 0;
  typedef struct {
    int p;
    logic we;
    logic [31:0] a;
    logic [1:0] len;
    int nb;
    logic [31:0] wd;
    logic [31:0] rd;
    int lat;
  } vec_t;
  vec_t tv [7];
  mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(0), .ADDR_W(32)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .len_i(len_i), .wdata_i(wdata_i), .gnt_o(gnt0), .done_o(done0),
    .rdata_o(rd0), .mem_din(din0), .mem_dout(dout0), .mem_a(ma0), .mem_wr(wr0));
  mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(1), .ADDR_W(32)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .len_i(len_i), .wdata_i(wdata_i), .gnt_o(gnt1), .done_o(done1),
    .rdata_o(rd1), .mem_din(din1), .mem_dout(dout1), .mem_a(ma1), .mem_wr(wr1));
  always #5 clk_in = ~clk_in;
  function automatic logic [7:0] memf(input logic [31:0] a);
    case (a)
      32'h100: memf = 8'h11;
      32'h101: memf = 8'h22;
      32'h102: memf = 8'h33;
      32'h103: memf = 8'h44;
      32'hFFFFFFFF: memf = 8'hA5;
      default: memf = a[7:0] ^ 8'h5A;
    endcase
  endfunction
  // memory model: address registered by the DUT, data registered here -> two-cycle read latency
  always @(posedge clk_in) begin
    din0 <= memf(ma0);
    din1 <= memf(ma1);
    if (wr0 && ma0[31:2] == 30'h100) wlog[ma0[1:0]] <= dout0;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic wait_done(output int j);
    j = 0;
    while (done0 == 2'b00 && j < 30) begin
      step();
      j++;
    end
    chk("done_seen", done0 != 2'b00, 1);
  endtask
  task automatic set_port(input int p, input logic we, input logic [31:0] a, input logic [1:0] len, input logic [31:0] wd);
    addr_i[p*32 +: 32] = a;
    len_i[p*2 +: 2] = len;
    wdata_i[p*32 +: 32] = wd;
    we_i[p] = we;
  endtask
  task automatic run_txn(input vec_t t);
    int j;
    set_port(t.p, t.we, t.a, t.len, t.wd);
    req_i[t.p] = 1'b1;
    step();
    chk("grant0", gnt0, 64'(1 << t.p));
    chk("grant1", gnt1, 64'(1 << t.p));
    j = 0;
    while (done0 == 2'b00 && j < 20) begin
      if (j < t.nb) begin
        chk("addr", ma0, 32'(t.a + j));
        chk("wr", wr0, t.we);
        if (t.we) chk("wdata", dout0, t.wd[8*j +: 8]);
      end
      step();
      j++;
    end
    chk("done_lat", j, t.lat);
    chk("done_vec0", done0, 64'(1 << t.p));
    chk("done_vec1", done1, 64'(1 << t.p));
    chk("gnt_held", gnt0, 64'(1 << t.p));
    chk("wr_in_done", wr0, 0);
    chk("addr_hold", ma0, 32'(t.a + t.nb - 1));
    chk("rdata0", rd0, t.rd);
    chk("rdata1", rd1, t.rd);
    step();
    req_i[t.p] = 1'b0;
    chk("idle_done", done0, 0);
    chk("idle_gnt", gnt0, 0);
    chk("idle_rdata", rd0, t.rd);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int j;
    logic [1:0] p0, p1;
    logic [1:0] g0 [$];
    logic [1:0] g1 [$];
    tv[0] = '{0, 1'b0, 32'h100, 2'd2, 4, 32'h0, 32'h44332211, 5};
    tv[1] = '{1, 1'b1, 32'h200, 2'd1, 2, 32'h0000BEEF, 32'h44332211, 2};
    tv[2] = '{1, 1'b0, 32'h102, 2'd1, 2, 32'h0, 32'h00004433, 3};
    tv[3] = '{0, 1'b1, 32'h300, 2'd3, 4, 32'hCAFEF00D, 32'h00004433, 4};
    tv[4] = '{0, 1'b0, 32'hFFFFFFFF, 2'd0, 1, 32'h0, 32'h000000A5, 2};
    tv[5] = '{1, 1'b0, 32'h55, 2'd0, 1, 32'h0, 32'h0000000F, 2};
    tv[6] = '{1, 1'b0, 32'h1F0, 2'd3, 4, 32'h0, 32'hA9A8ABAA, 5};
    #3;
    chk("rst_gnt", gnt0, 0);
    chk("rst_done", done0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_addr", ma0, 0);
    chk("rst_wr", wr0, 0);
    chk("rst_dout", dout0, 0);
    step();
    rst_in = 1'b1;
    step();
    for (int i = 0; i < 7; i++) run_txn(tv[i]);
    // read stalled for three cycles after byte 1 is issued
    set_port(0, 1'b0, 32'h100, 2'd2, 32'h0);
    req_i[0] = 1'b1;
    step();
    step();
    chk("stall_addr1", ma0, 32'h101);
    rdy_in = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_rd_wr", wr0, 0);
      chk("stall_rd_addr", ma0, 32'h101);
      chk("stall_rd_done", done0, 0);
      step();
    end
    rdy_in = 1'b1;
    wait_done(j);
    chk("stall_rdata", rd0, 32'h44332211);
    step();
    req_i[0] = 1'b0;
    // write stalled while byte 1 is on the bus; the byte must be re-driven
    set_port(1, 1'b1, 32'h400, 2'd2, 32'h89ABCDEF);
    req_i[1] = 1'b1;
    step();
    step();
    chk("wstall_pre_wr", wr0, 1);
    rdy_in = 1'b0;
    #1;
    chk("wstall_wr", wr0, 0);
    chk("wstall_dout", dout0, 8'hCD);
    chk("wstall_addr", ma0, 32'h401);
    repeat (3) step();
    chk("wstall_frozen_wr", wr0, 0);
    rdy_in = 1'b1;
    #1;
    chk("wstall_redrive", {wr0, dout0}, {1'b1, 8'hCD});
    wait_done(j);
    chk("wstall_mem", {wlog[3], wlog[2], wlog[1], wlog[0]}, 32'h89ABCDEF);
    step();
    req_i[1] = 1'b0;
    step();
    // reset during byte 1 of a port-0 write
    set_port(0, 1'b1, 32'h300, 2'd3, 32'h12345678);
    req_i[0] = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    #1;
    chk("mrst_gnt0", gnt0, 0);
    chk("mrst_gnt1", gnt1, 0);
    chk("mrst_done", done0, 0);
    chk("mrst_rdata", rd0, 0);
    chk("mrst_addr", ma0, 0);
    chk("mrst_dout", dout0, 0);
    chk("mrst_wr", wr0, 0);
    req_i = '0;
    step();
    rst_in = 1'b1;
    repeat (4) begin
      step();
      chk("mrst_no_done", {done0, done1}, 0);
    end
    // both ports requesting continuously
    set_port(0, 1'b0, 32'h100, 2'd0, 32'h0);
    set_port(1, 1'b0, 32'h55, 2'd0, 32'h0);
    req_i = 2'b11;
    p0 = '0;
    p1 = '0;
    for (int c = 0; c < 40; c++) begin
      if (gnt0 != 2'b00 && p0 == 2'b00) g0.push_back(gnt0);
      if (gnt1 != 2'b00 && p1 == 2'b00) g1.push_back(gnt1);
      p0 = gnt0;
      p1 = gnt1;
      step();
    end
    chk("fp_count", g0.size() >= 4, 1);
    chk("rr_count", g1.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < g0.size()) chk("fp_grant", g0[i], 2'b01);
      if (i < g1.size()) chk("rr_grant", g1[i], i % 2 == 0 ? 2'b01 : 2'b10);
    end
    req_i = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
